// File: rtl/counter_bank_pkg.sv
// Shared types and limits for the counter_bank timing/event counter core.
package counter_bank_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_e;

  localparam int CNT_WIDTH_MAX = 32;
  localparam int CNT_NCH_MAX   = 16;

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: count register, terminal-count pulse and optional sticky irq flag.
// Optional feature: COUNTER_BANK_IRQ_EN adds irq_clear_i / irq_flag_o and the flag register.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic             enable_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] limit_i,
`ifdef COUNTER_BANK_IRQ_EN
  input  logic             irq_clear_i,
  output logic             irq_flag_o,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] cnt_inc, cnt_dec;
  cnt_mode_e        mode_e;
  cnt_dir_e         dir_e;

  assign cnt_inc = count_q + ONE;
  assign cnt_dec = count_q - ONE;
  assign mode_e  = cnt_mode_e'(mode_i);
  assign dir_e   = cnt_dir_e'(dir_i);

  // Priority: load, out-of-range recovery, step, hold.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load_i) begin
      count_d = (load_value_i > limit_i) ? limit_i : load_value_i;
    end else if (enable_i) begin
      if (count_q > limit_i) begin
        count_d = limit_i;
      end else if (mode_e == CNT_WRAP) begin
        if (dir_e == CNT_UP) begin
          if (count_q == limit_i) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = cnt_inc;
          end
        end else begin
          if (count_q == '0) begin
            count_d = limit_i;
            tc_d    = 1'b1;
          end else begin
            count_d = cnt_dec;
          end
        end
      end else begin
        // Saturate: tc marks arrival at the bound, not sitting on it.
        if (dir_e == CNT_UP) begin
          if (count_q < limit_i) begin
            count_d = cnt_inc;
            tc_d    = (cnt_inc == limit_i);
          end
        end else begin
          if (count_q > '0) begin
            count_d = cnt_dec;
            tc_d    = (cnt_dec == '0);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= RESET_VALUE;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;

`ifdef COUNTER_BANK_IRQ_EN
  logic irq_q, irq_d;

  // A new terminal event beats a simultaneous clear.
  always_comb begin
    irq_d = irq_q;
    if (irq_clear_i) irq_d = 1'b0;
    if (tc_d)        irq_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end

  assign irq_flag_o = irq_q;
`endif

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH independent up/down wrap/saturate counters with terminal-count pulses.
// Optional feature: COUNTER_BANK_IRQ_EN adds irq_clear, irq_status and irq.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NCH         = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic                 aclk,
  input  logic                 areset,
`ifdef COUNTER_BANK_IRQ_EN
  input  logic [NCH-1:0]       irq_clear,
  output logic [NCH-1:0]       irq_status,
  output logic                 irq,
`endif
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] load_value,
  input  logic [NCH-1:0]       enable,
  input  logic [NCH-1:0]       inc_dec,
  input  logic [NCH-1:0]       mode,
  input  logic [NCH*WIDTH-1:0] limit,
  output logic [NCH*WIDTH-1:0] count_out,
  output logic [NCH-1:0]       tc
);

  if ((WIDTH < 2) || (WIDTH > CNT_WIDTH_MAX)) begin : g_bad_width
    $error("counter_bank: WIDTH out of range");
  end
  if ((NCH < 1) || (NCH > CNT_NCH_MAX)) begin : g_bad_nch
    $error("counter_bank: NCH out of range");
  end

  localparam logic [WIDTH-1:0] RST_VAL = RESET_VALUE[WIDTH-1:0];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    counter_bank_ch #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RST_VAL)
    ) u_ch (
      .clk_i        (aclk),
      .rst_i        (areset),
      .load_i       (load[i]),
      .load_value_i (load_value[i*WIDTH +: WIDTH]),
      .enable_i     (enable[i]),
      .dir_i        (inc_dec[i]),
      .mode_i       (mode[i]),
      .limit_i      (limit[i*WIDTH +: WIDTH]),
`ifdef COUNTER_BANK_IRQ_EN
      .irq_clear_i  (irq_clear[i]),
      .irq_flag_o   (irq_status[i]),
`endif
      .count_o      (count_out[i*WIDTH +: WIDTH]),
      .tc_o         (tc[i])
    );
  end

`ifdef COUNTER_BANK_IRQ_EN
  assign irq = |irq_status;
`endif

endmodule

// File: tb/tb_counter_bank.sv
// Directed scoreboard bench for counter_bank (WIDTH=8, NCH=4, RESET_VALUE=5).
// Handles both builds, with and without COUNTER_BANK_IRQ_EN.
module tb_counter_bank;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int EXW = 41;  // {irq_status, irq, tc, count_out}

  logic           aclk;
  logic           areset;
  logic [N-1:0]   load;
  logic [N*W-1:0] load_value;
  logic [N-1:0]   enable;
  logic [N-1:0]   inc_dec;
  logic [N-1:0]   mode;
  logic [N*W-1:0] limit;
  logic [N*W-1:0] count_out;
  logic [N-1:0]   tc;
`ifdef COUNTER_BANK_IRQ_EN
  logic [N-1:0]   irq_clear;
  logic [N-1:0]   irq_status;
  logic           irq;
`endif

  counter_bank #(
    .WIDTH       (W),
    .NCH         (N),
    .RESET_VALUE (5)
  ) dut (
    .aclk       (aclk),
    .areset     (areset),
`ifdef COUNTER_BANK_IRQ_EN
    .irq_clear  (irq_clear),
    .irq_status (irq_status),
    .irq        (irq),
`endif
    .load       (load),
    .load_value (load_value),
    .enable     (enable),
    .inc_dec    (inc_dec),
    .mode       (mode),
    .limit      (limit),
    .count_out  (count_out),
    .tc         (tc)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // scoreboard state
  logic [EXW-1:0] exp_q[$];
  int             n_checks = 0;
  int             n_errors = 0;
  logic [W-1:0]   cnt [N];
  logic [N-1:0]   exp_irq;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: called at a negedge with inputs already set; pushes the
  // response expected after the coming rising edge
  task automatic step(input logic [N-1:0] tcx, input logic [N-1:0] clr);
`ifdef COUNTER_BANK_IRQ_EN
    irq_clear = clr;
`endif
    exp_irq = (exp_irq & ~clr) | tcx;
    exp_q.push_back({exp_irq, |exp_irq, tcx, cnt[3], cnt[2], cnt[1], cnt[0]});
    @(negedge aclk);
  endtask

  // monitor
  initial begin
    logic [EXW-1:0] e;
    forever begin
      @(posedge aclk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count_out", 64'(count_out), 64'(e[31:0]));
        check("tc", 64'(tc), 64'(e[35:32]));
`ifdef COUNTER_BANK_IRQ_EN
        check("irq", 64'(irq), 64'(e[36]));
        check("irq_status", 64'(irq_status), 64'(e[40:37]));
`endif
      end
    end
  end

  initial begin
    areset = 1'b1;
    load = '0; load_value = '0; enable = '0; inc_dec = '0; mode = '0; limit = '0;
`ifdef COUNTER_BANK_IRQ_EN
    irq_clear = '0;
`endif
    exp_irq = '0;
    for (int i = 0; i < N; i++) cnt[i] = 8'd5;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    check("reset_count", 64'(count_out), 64'h05050505);
    check("reset_tc", 64'(tc), 64'h0);
    @(negedge aclk);
    limit = {4{8'd255}};
    step(4'b0000, 4'b0000);

    // wrap up on ch0: limit 9, load 7
    limit[7:0] = 8'd9; load = 4'b0001; load_value[7:0] = 8'd7;
    cnt[0] = 8'd7; step(4'b0000, 4'b0000);
    load = '0; enable = 4'b0001;
    cnt[0] = 8'd8; step(4'b0000, 4'b0000);
    cnt[0] = 8'd9; step(4'b0000, 4'b0000);
    cnt[0] = 8'd0; step(4'b0001, 4'b0000);
    cnt[0] = 8'd1; step(4'b0000, 4'b0000);
    enable = '0;

    // saturate down on ch1: limit 200, load 2
    limit[15:8] = 8'd200; mode[1] = 1'b1; inc_dec[1] = 1'b1;
    load = 4'b0010; load_value[15:8] = 8'd2;
    cnt[1] = 8'd2; step(4'b0000, 4'b0000);
    load = '0; enable = 4'b0010;
    cnt[1] = 8'd1; step(4'b0000, 4'b0000);
    cnt[1] = 8'd0; step(4'b0010, 4'b0000);
    cnt[1] = 8'd0; step(4'b0000, 4'b0000);
    cnt[1] = 8'd0; step(4'b0000, 4'b0000);
    enable = '0;

    // load clamp over enable, then runtime limit drop on ch2
    limit[23:16] = 8'd30; load = 4'b0100; enable = 4'b0100; load_value[23:16] = 8'd50;
    cnt[2] = 8'd30; step(4'b0000, 4'b0000);
    load = '0; limit[23:16] = 8'd10;
    cnt[2] = 8'd10; step(4'b0000, 4'b0000);
    enable = '0;

    // independence: ch0 up wrap limit 3, ch3 down saturate limit 255
    limit[7:0] = 8'd3; mode[3] = 1'b1; inc_dec[3] = 1'b1;
    load = 4'b1001; load_value[7:0] = 8'd0; load_value[31:24] = 8'd255;
    cnt[0] = 8'd0; cnt[3] = 8'd255; step(4'b0000, 4'b0000);
    load = '0; enable = 4'b1001;
    for (int i = 1; i <= 10; i++) begin
      cnt[0] = 8'(i % 4);
      cnt[3] = 8'(255 - i);
      step((i % 4 == 0) ? 4'b0001 : 4'b0000, 4'b0000);
    end
    enable = '0;

    // limit 0: wrap pulses every step in both directions, saturate never
    limit[15:8] = 8'd0; mode[1] = 1'b0; enable = 4'b0010;
    cnt[1] = 8'd0; step(4'b0010, 4'b0000);
    inc_dec[1] = 1'b0;
    step(4'b0010, 4'b0000);
    step(4'b0010, 4'b0000);
    mode[1] = 1'b1;
    step(4'b0000, 4'b0000);
    enable = '0;

    // full-range limit on ch3 gives natural modulo wrap
    mode[3] = 1'b0; inc_dec[3] = 1'b0; load = 4'b1000; load_value[31:24] = 8'd254;
    cnt[3] = 8'd254; step(4'b0000, 4'b0000);
    load = '0; enable = 4'b1000;
    cnt[3] = 8'd255; step(4'b0000, 4'b0000);
    cnt[3] = 8'd0;   step(4'b1000, 4'b0000);
    enable = '0;

    // saturate up on ch2, limit 10: tc on arrival only
    mode[2] = 1'b1; inc_dec[2] = 1'b0; load = 4'b0100; load_value[23:16] = 8'd8;
    cnt[2] = 8'd8; step(4'b0000, 4'b0000);
    load = '0; enable = 4'b0100;
    cnt[2] = 8'd9;  step(4'b0000, 4'b0000);
    cnt[2] = 8'd10; step(4'b0100, 4'b0000);
    cnt[2] = 8'd10; step(4'b0000, 4'b0000);
    enable = '0;

    // sticky flags: clear all, tc on ch2, set beats clear, lone clear
    step(4'b0000, 4'b1111);
    mode[2] = 1'b0; limit[23:16] = 8'd2; load = 4'b0100; load_value[23:16] = 8'd1;
    cnt[2] = 8'd1; step(4'b0000, 4'b0000);
    load = '0; enable = 4'b0100;
    cnt[2] = 8'd2; step(4'b0000, 4'b0000);
    cnt[2] = 8'd0; step(4'b0100, 4'b0000);
    cnt[2] = 8'd1; step(4'b0000, 4'b0000);
    cnt[2] = 8'd2; step(4'b0000, 4'b0000);
    cnt[2] = 8'd0; step(4'b0100, 4'b0100);
    enable = '0;
    step(4'b0000, 4'b0100);
    step(4'b0000, 4'b0000);

    // mid-count reset while tc and irq are high on ch0 (count 2, limit 3)
    enable = 4'b0001;
    cnt[0] = 8'd3; step(4'b0000, 4'b0000);
    cnt[0] = 8'd0; step(4'b0001, 4'b0000);
    #2 areset = 1'b1;
    #1;
    check("async_reset_count", 64'(count_out), 64'h05050505);
    check("async_reset_tc", 64'(tc), 64'h0);
`ifdef COUNTER_BANK_IRQ_EN
    check("async_reset_irq", 64'({irq_status, irq}), 64'h0);
`endif
    @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    exp_irq = '0;
    for (int i = 0; i < N; i++) cnt[i] = 8'd5;
    // first edge after release: ch0 recovers 5 -> limit 3, then wraps
    cnt[0] = 8'd3; step(4'b0000, 4'b0000);
    cnt[0] = 8'd0; step(4'b0001, 4'b0000);
    enable = '0;

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge aclk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_bank.md
# counter_bank

Parametrised bank of NCH independent up/down counters, each WIDTH bits wide with explicit load, a per-channel programmable limit, and wrap or saturate mode. It is the general-purpose timing/event counter peripheral core. It sits behind the bus-slave register wrapper. Each channel flags terminal count with a one-cycle pulse, and optionally with a sticky interrupt.

## Interface
- WIDTH, 8: counter width in bits (2..32)
- NCH, 4: number of channels (1..16)
- RESET_VALUE, 0: count value after reset, all channels
- aclk  in  1  clock, all logic rising-edge
- areset  in  1  asynchronous, active-high reset
- load  in  NCH  per-channel synchronous load strobe
- load_value  in  NCH*WIDTH  load data; channel i at [i*WIDTH +: WIDTH]
- enable  in  NCH  per-channel count enable
- inc_dec  in  NCH  direction: 0 = increment, 1 = decrement
- mode  in  NCH  0 = wrap, 1 = saturate
- limit  in  NCH*WIDTH  per-channel upper bound; legal count range 0..limit
- count_out  out  NCH*WIDTH  registered count
- tc  out  NCH  registered one-cycle terminal-count pulse
- irq_clear  in  NCH  write-1-to-clear for irq_status (COUNTER_BANK_IRQ_EN only)
- irq_status  out  NCH  sticky terminal-count flags (COUNTER_BANK_IRQ_EN only)
- irq  out  1  OR of irq_status (COUNTER_BANK_IRQ_EN only)

## Operation
- Channels are fully independent and share only aclk and areset.
- Per-channel priority, evaluated each cycle: load, then out-of-range recovery, then step, then hold.
- Load: count <= min(load_value, limit). tc = 0. Load does not depend on enable.
- Recovery: if enable is set and count > limit (limit lowered at runtime), count <= limit. tc = 0, regardless of mode and direction.
- Step up, wrap mode: count == limit gives count <= 0 and tc = 1. Otherwise count + 1.
- Step down, wrap mode: count == 0 gives count <= limit and tc = 1. Otherwise count − 1.
- Step up, saturate mode: count < limit gives count + 1. tc = 1 only when the new count equals limit. count == limit holds with tc = 0.
- Step down, saturate mode: count > 0 gives count − 1. tc = 1 only when the new count is 0. count == 0 holds with tc = 0.
- limit == 0: count is forced to 0. Wrap mode pulses tc on every enabled step. Saturate mode never pulses tc.
- Hold: with enable low and no load, count and direction-independent state are unchanged and tc = 0.
- Arithmetic is WIDTH-bit unsigned. No carry or borrow escapes the channel. limit == 2^WIDTH−1 gives natural modulo-2^WIDTH wrap.

## Timing
- All inputs are sampled on the rising edge of aclk.
- count_out and tc update on the same edge, giving 1-cycle latency from stimulus to output.
- tc is high for exactly one cycle per terminal event. Back-to-back events give a continuous high level, e.g. limit 0 in wrap mode with enable held high.
- Changes to mode, inc_dec and limit take effect on the next edge. No pipeline is flushed.
- areset (asynchronous assert, synchronous release by the system reset synchroniser):
  - count_out = RESET_VALUE
  - tc = 0
  - irq_status = 0
  - irq = 0
- Reset asserted mid-count aborts immediately. The first edge after release evaluates normally.

## Configuration
- COUNTER_BANK_IRQ_EN defined: the irq_clear, irq_status and irq ports exist.
  - irq_status[i] sets on the edge where tc[i] sets, and clears on irq_clear[i].
  - If set and clear occur in the same cycle, set wins.
  - irq is the combinational OR of the irq_status registers.
- COUNTER_BANK_IRQ_EN undefined: these ports and their flops are absent. All other behaviour is identical.

## Structure
- Shared package counter_bank_pkg holds:
  - typedef cnt_mode_e {CNT_WRAP = 0, CNT_SAT = 1}
  - typedef cnt_dir_e {CNT_UP = 0, CNT_DOWN = 1}
  - constants CNT_WIDTH_MAX = 32 and CNT_NCH_MAX = 16
- Sub-module counter_bank_ch implements one channel: count register, tc and optional irq flag.
- The top module is a generate loop over NCH, plus the irq OR-reduction and parameter range assertions.

## Test plan
- Reset: WIDTH=8, NCH=4, RESET_VALUE=5. Assert areset mid-count → all counts = 5, tc = 0, irq = 0 asynchronously, before the next aclk edge.
- Wrap up: limit=9, mode=0, inc_dec=0, load 7, enable for 4 cycles → counts 8, 9, 0, 1. tc high only in the cycle count becomes 0.
- Saturate down: limit=200, mode=1, inc_dec=1, load 2, enable for 4 cycles → counts 1, 0, 0, 0. tc high only in the cycle count becomes 0.
- Load priority and clamp:
  - load=1 with enable=1, load_value=50, limit=30 → count 30, tc 0.
  - Then lower limit to 10 with enable → count 10, tc 0.
- Channel independence: ch0 up wrap with limit 3, ch3 down saturate with limit 255, both enabled for 10 cycles → ch0 cycles 0..3 with tc every 4th step. ch3 goes 255 → 245 with no tc. ch1 and ch2 are unchanged.
- IRQ (COUNTER_BANK_IRQ_EN): tc on ch2 → irq_status = 4'b0100 and irq = 1. irq_clear[2] in the same cycle as a new tc on ch2 → flag stays set. A later lone irq_clear → flag = 0 and irq = 0.
